// File: rtl/lbm_pkg.sv
// lbm_pkg: shared definitions for the LBM_DE2 D2Q9 datapath.
//   - lattice direction indices and the cx/cy velocity tables
//   - the moment-stage FSM state encoding
//   - width/iteration derivations for the moment sums and divider
//   - 8.24 fixed-point helpers shared with the collision stage
package lbm_pkg;

    localparam int LBM_Q = 9;

    // Direction order used by the packed distribution word.
    localparam int DIR_REST = 0;
    localparam int DIR_E    = 1;
    localparam int DIR_N    = 2;
    localparam int DIR_W    = 3;
    localparam int DIR_S    = 4;
    localparam int DIR_NE   = 5;
    localparam int DIR_NW   = 6;
    localparam int DIR_SW   = 7;
    localparam int DIR_SE   = 8;

    localparam int LBM_CX [LBM_Q] = '{0, 1, 0, -1,  0, 1, -1, -1,  1};
    localparam int LBM_CY [LBM_Q] = '{0, 0, 1,  0, -1, 1,  1, -1, -1};

    // Nine-term sums need headroom beyond one data word.
    localparam int LBM_SUM_GUARD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } lbm_state_e;

    function automatic int lbm_sum_width(input int data_width);
        return data_width + LBM_SUM_GUARD;
    endfunction

    // One quotient bit per cycle over the whole (|m| << frac) dividend.
    function automatic int lbm_iter(input int data_width, input int frac_bits);
        return lbm_sum_width(data_width) + frac_bits;
    endfunction

    // 8.24 helpers
    localparam int          FX_FRAC = 24;
    localparam logic [31:0] FX_ONE  = 32'h0100_0000;

    function automatic logic [31:0] fx_mul(input logic signed [31:0] a,
                                           input logic signed [31:0] b);
        logic signed [63:0] prod;
        prod = a * b;
        return prod[FX_FRAC +: 32];
    endfunction

endpackage

// File: rtl/lbm_seq_divider.sv
// lbm_seq_divider: restoring unsigned divider, one quotient bit per cycle.
//   CLOCK_50, RESET : clock, asynchronous active-high reset
//   start           : load dividend/divisor and begin (ignored bits of state discarded)
//   dividend        : DIVIDEND_WIDTH-bit unsigned numerator
//   divisor         : DIVISOR_WIDTH-bit unsigned denominator
//   busy            : iterations in progress
//   done            : high during the final iteration cycle; quotient is valid then
//   quotient        : quotient including the bit produced this cycle
// The run takes DIVIDEND_WIDTH cycles after start. A zero divisor yields garbage.
module lbm_seq_divider #(
    parameter int DIVIDEND_WIDTH = 60,
    parameter int DIVISOR_WIDTH  = 36
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient
);

    localparam int CNT_WIDTH = $clog2(DIVIDEND_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DIVIDEND_WIDTH - 1);

    // q_reg shifts dividend bits out of its top while quotient bits enter at the bottom.
    logic [DIVIDEND_WIDTH-1:0] q_reg;
    logic [DIVISOR_WIDTH-1:0]  rem_reg;
    logic [DIVISOR_WIDTH-1:0]  divisor_reg;
    logic [CNT_WIDTH-1:0]      count_reg;
    logic                      busy_reg;

    logic [DIVISOR_WIDTH:0]    rem_shift;
    logic [DIVISOR_WIDTH:0]    rem_diff;
    logic [DIVISOR_WIDTH-1:0]  rem_next;
    logic                      take;

    // rem_reg < divisor always, so the trial difference is negative exactly
    // when its top bit is set.
    assign rem_shift = {rem_reg, q_reg[DIVIDEND_WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor_reg};
    assign take      = ~rem_diff[DIVISOR_WIDTH];
    assign rem_next  = take ? rem_diff[DIVISOR_WIDTH-1:0] : rem_shift[DIVISOR_WIDTH-1:0];

    assign busy     = busy_reg;
    assign done     = busy_reg && (count_reg == LAST);
    assign quotient = {q_reg[DIVIDEND_WIDTH-2:0], take};

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            q_reg       <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
        end else if (start) begin
            q_reg       <= dividend;
            rem_reg     <= '0;
            divisor_reg <= divisor;
            count_reg   <= '0;
            busy_reg    <= 1'b1;
        end else if (busy_reg) begin
            q_reg     <= quotient;
            rem_reg   <= rem_next;
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lbm_macro_moments.sv
// lbm_macro_moments: density and velocity moments of one D2Q9 cell.
//   CLOCK_50, RESET       : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake for fin_in (9 x 8.24 signed) and addr_in
//   out_valid/out_ready   : output handshake for p_out, ux_out, uy_out, addr_out, ovf_out
//   p_out                 : rho, low DATA_WIDTH bits
//   ux_out, uy_out        : momentum / rho, 8.24 signed
//   ovf_out               : velocity saturated
// Optional feature macro: LBM_MACRO_SAT_EN enables velocity saturation and
// ovf_out; without it the quotient wraps and ovf_out is constant 0.
// Latency: ITER+1 cycles from the accepting edge to out_valid.
module lbm_macro_moments
    import lbm_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int FRACTIONAL_BITS = 24,
    parameter int DATA_WIDTH_F    = 9 * DATA_WIDTH,
    parameter int ADDRESS_WIDTH   = 8
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH_F-1:0]  fin_in,
    input  logic [ADDRESS_WIDTH-1:0] addr_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    p_out,
    output logic [DATA_WIDTH-1:0]    ux_out,
    output logic [DATA_WIDTH-1:0]    uy_out,
    output logic [ADDRESS_WIDTH-1:0] addr_out,
    output logic                     ovf_out
);

    localparam int SUM_WIDTH = lbm_sum_width(DATA_WIDTH);
    localparam int ITER      = lbm_iter(DATA_WIDTH, FRACTIONAL_BITS);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_SUM  = SUM;
    localparam logic [1:0] S_DIV  = DIV;
    localparam logic [1:0] S_DONE = DONE;

`ifdef LBM_MACRO_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    logic [1:0]               state_reg, state_next;
    logic                     in_ready_reg;
    logic                     out_valid_reg;
    logic [DATA_WIDTH_F-1:0]  fin_reg;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0]    p_reg;
    logic                     rho_pos_reg;
    logic                     mx_neg_reg, my_neg_reg;
    logic [DATA_WIDTH-1:0]    p_out_reg, ux_out_reg, uy_out_reg;
    logic [ADDRESS_WIDTH-1:0] addr_out_reg;
    logic                     ovf_out_reg;

    logic signed [SUM_WIDTH-1:0] f_ext [LBM_Q];
    logic signed [SUM_WIDTH-1:0] rho_sum, mx_sum, my_sum;
    logic [SUM_WIDTH-1:0]        mx_mag, my_mag;

    logic            accept;
    logic            div_start;
    logic            ux_busy, uy_busy, ux_done, uy_done;
    logic [ITER-1:0] ux_quot, uy_quot;
    logic            div_last;
    logic [DATA_WIDTH:0] ux_shaped, uy_shaped;

    // Sign-extend each distribution to the sum width.
    genvar gi;
    generate
        for (gi = 0; gi < LBM_Q; gi++) begin : g_ext
            assign f_ext[gi] = {{LBM_SUM_GUARD{fin_reg[gi*DATA_WIDTH + DATA_WIDTH-1]}},
                                fin_reg[gi*DATA_WIDTH +: DATA_WIDTH]};
        end
    endgenerate

    always_comb begin
        rho_sum = '0;
        mx_sum  = '0;
        my_sum  = '0;
        for (int i = 0; i < LBM_Q; i++) begin
            rho_sum = rho_sum + f_ext[i];
            if (LBM_CX[i] > 0)      mx_sum = mx_sum + f_ext[i];
            else if (LBM_CX[i] < 0) mx_sum = mx_sum - f_ext[i];
            if (LBM_CY[i] > 0)      my_sum = my_sum + f_ext[i];
            else if (LBM_CY[i] < 0) my_sum = my_sum - f_ext[i];
        end
    end

    // Divide magnitudes; the sign is reapplied once the quotient is known.
    assign mx_mag = mx_sum[SUM_WIDTH-1] ? (~mx_sum + 1'b1) : mx_sum;
    assign my_mag = my_sum[SUM_WIDTH-1] ? (~my_sum + 1'b1) : my_sum;

    assign accept    = (state_reg == S_IDLE) && in_valid && in_ready_reg;
    assign div_start = (state_reg == S_SUM);
    assign div_last  = ux_done && uy_done;

    lbm_seq_divider #(
        .DIVIDEND_WIDTH(ITER),
        .DIVISOR_WIDTH (SUM_WIDTH)
    ) u_div_ux (
        .CLOCK_50(CLOCK_50),
        .RESET   (RESET),
        .start   (div_start),
        .dividend({mx_mag, {FRACTIONAL_BITS{1'b0}}}),
        .divisor ($unsigned(rho_sum)),
        .busy    (ux_busy),
        .done    (ux_done),
        .quotient(ux_quot)
    );

    lbm_seq_divider #(
        .DIVIDEND_WIDTH(ITER),
        .DIVISOR_WIDTH (SUM_WIDTH)
    ) u_div_uy (
        .CLOCK_50(CLOCK_50),
        .RESET   (RESET),
        .start   (div_start),
        .dividend({my_mag, {FRACTIONAL_BITS{1'b0}}}),
        .divisor ($unsigned(rho_sum)),
        .busy    (uy_busy),
        .done    (uy_done),
        .quotient(uy_quot)
    );

    // Returns {ovf, velocity}. Non-positive density forces a clean zero.
    function automatic logic [DATA_WIDTH:0] shape_velocity(input logic [ITER-1:0] quot,
                                                           input logic            neg,
                                                           input logic            rho_pos);
        logic [DATA_WIDTH-1:0] mag_lo;
        logic [DATA_WIDTH-1:0] val;
        logic                  over;
        mag_lo = quot[DATA_WIDTH-1:0];
        over   = |quot[ITER-1:DATA_WIDTH-1];
        val    = neg ? (~mag_lo + 1'b1) : mag_lo;
        if (!rho_pos) begin
            return '0;
        end
        if (SAT_EN && over) begin
            return {1'b1, neg ? SAT_NEG : SAT_POS};
        end
        return {1'b0, val};
    endfunction

    assign ux_shaped = shape_velocity(ux_quot, mx_neg_reg, rho_pos_reg);
    assign uy_shaped = shape_velocity(uy_quot, my_neg_reg, rho_pos_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = S_SUM;
            S_SUM:  state_next = S_DIV;
            S_DIV: begin
                if (div_last) begin
                    state_next = S_DONE;
                end else if (!(ux_busy && uy_busy)) begin
                    // Dividers dropped out without finishing: nothing to report.
                    state_next = S_IDLE;
                end
            end
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_reg     <= S_IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            fin_reg       <= '0;
            addr_reg      <= '0;
            p_reg         <= '0;
            rho_pos_reg   <= 1'b0;
            mx_neg_reg    <= 1'b0;
            my_neg_reg    <= 1'b0;
            p_out_reg     <= '0;
            ux_out_reg    <= '0;
            uy_out_reg    <= '0;
            addr_out_reg  <= '0;
            ovf_out_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next == S_IDLE);
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        fin_reg  <= fin_in;
                        addr_reg <= addr_in;
                    end
                end
                S_SUM: begin
                    p_reg       <= rho_sum[DATA_WIDTH-1:0];
                    rho_pos_reg <= !rho_sum[SUM_WIDTH-1] && (rho_sum != '0);
                    mx_neg_reg  <= mx_sum[SUM_WIDTH-1];
                    my_neg_reg  <= my_sum[SUM_WIDTH-1];
                end
                S_DIV: begin
                    if (div_last) begin
                        p_out_reg     <= p_reg;
                        ux_out_reg    <= ux_shaped[DATA_WIDTH-1:0];
                        uy_out_reg    <= uy_shaped[DATA_WIDTH-1:0];
                        ovf_out_reg   <= ux_shaped[DATA_WIDTH] | uy_shaped[DATA_WIDTH];
                        addr_out_reg  <= addr_reg;
                        out_valid_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign p_out     = p_out_reg;
    assign ux_out    = ux_out_reg;
    assign uy_out    = uy_out_reg;
    assign addr_out  = addr_out_reg;
    assign ovf_out   = ovf_out_reg;

endmodule

// File: tb/tb_lbm_macro_moments.sv
module tb_lbm_macro_moments;

    localparam int DW   = 32;
    localparam int FB   = 24;
    localparam int DWF  = 9 * DW;
    localparam int AW   = 8;
    localparam int ITER = DW + 4 + FB;

    logic           CLOCK_50 = 1'b0;
    logic           RESET    = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DWF-1:0] fin_in   = '0;
    logic [AW-1:0]  addr_in  = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [DW-1:0]  p_out, ux_out, uy_out;
    logic [AW-1:0]  addr_out;
    logic           ovf_out;

    always #5 CLOCK_50 = ~CLOCK_50;

    lbm_macro_moments #(
        .DATA_WIDTH     (DW),
        .FRACTIONAL_BITS(FB),
        .DATA_WIDTH_F   (DWF),
        .ADDRESS_WIDTH  (AW)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fin_in   (fin_in),
        .addr_in  (addr_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p_out    (p_out),
        .ux_out   (ux_out),
        .uy_out   (uy_out),
        .addr_out (addr_out),
        .ovf_out  (ovf_out)
    );

    typedef struct packed {
        logic [31:0] p;
        logic [31:0] ux;
        logic [31:0] uy;
        logic [7:0]  addr;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] fv [9];

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference velocity: {ovf, value}.
    function automatic logic [32:0] exp_vel(input logic signed [35:0] m,
                                            input logic signed [35:0] rho);
        longint      mm, rr;
        logic [63:0] mag, q;
        logic [31:0] r;
        if (rho <= 0) return '0;
        mm  = m;
        rr  = rho;
        mag = (mm < 0) ? 64'(-mm) : 64'(mm);
        q   = (mag << 24) / 64'(rr);
`ifdef LBM_MACRO_SAT_EN
        if (q >= 64'h8000_0000) return {1'b1, (mm < 0) ? 32'h8000_0001 : 32'h7FFF_FFFF};
`endif
        r = q[31:0];
        if (mm < 0) r = -r;
        return {1'b0, r};
    endfunction

    function automatic exp_t model(input logic [DWF-1:0] fin, input logic [7:0] addr);
        logic signed [35:0] f [9];
        logic signed [35:0] rho, mx, my;
        logic [32:0]        vx, vy;
        exp_t               e;
        rho = '0;
        for (int i = 0; i < 9; i++) begin
            f[i] = {{4{fin[i*32+31]}}, fin[i*32 +: 32]};
            rho  = rho + f[i];
        end
        mx = f[1] + f[5] + f[8] - f[3] - f[6] - f[7];
        my = f[2] + f[5] + f[6] - f[4] - f[7] - f[8];
        vx = exp_vel(mx, rho);
        vy = exp_vel(my, rho);
        e.p    = rho[31:0];
        e.ux   = vx[31:0];
        e.uy   = vy[31:0];
        e.addr = addr;
        e.ovf  = vx[32] | vy[32];
        return e;
    endfunction

    // Drives fv as one cell; returns #1 after the accepting edge.
    task automatic send_cell(input logic [7:0] addr);
        int             waited = 0;
        logic [DWF-1:0] fin;
        for (int i = 0; i < 9; i++) fin[i*32 +: 32] = fv[i];
        while (!in_ready && waited < 300) begin
            @(posedge CLOCK_50); #1;
            waited++;
        end
        check_value("in_ready_wait", 64'(in_ready), 64'd1);
        sb_q.push_back(model(fin, addr));
        fin_in   = fin;
        addr_in  = addr;
        in_valid = 1'b1;
        @(posedge CLOCK_50); #1;
        in_valid = 1'b0;
        fin_in   = '0;
    endtask

    task automatic collect(input int stall);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 300) begin
            @(posedge CLOCK_50); #1;
            n++;
            if (n == 30) check_value("in_ready_busy", 64'(in_ready), 64'd0);
        end
        check_value("latency", 64'(n), 64'(ITER + 1));
        if (sb_q.size() == 0) begin
            check_value("sb_empty", 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        $display("[TB] cell addr=%02h p=%08h ux=%08h uy=%08h ovf=%0d latency=%0d",
                 addr_out, p_out, ux_out, uy_out, ovf_out, n);
        check_value("p_out",    64'(p_out),    64'(e.p));
        check_value("ux_out",   64'(ux_out),   64'(e.ux));
        check_value("uy_out",   64'(uy_out),   64'(e.uy));
        check_value("addr_out", 64'(addr_out), 64'(e.addr));
        check_value("ovf_out",  64'(ovf_out),  64'(e.ovf));
        for (int s = 0; s < stall; s++) begin
            @(posedge CLOCK_50); #1;
            check_value("stall_valid",    64'(out_valid), 64'd1);
            check_value("stall_in_ready", 64'(in_ready),  64'd0);
            check_value("stall_ux",       64'(ux_out),    64'(e.ux));
            check_value("stall_p",        64'(p_out),     64'(e.p));
        end
        out_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        out_ready = 1'b0;
        check_value("hs_valid_low",  64'(out_valid), 64'd0);
        check_value("hs_in_ready",   64'(in_ready),  64'd1);
    endtask

    task automatic run_cell(input logic [7:0] addr, input int stall);
        send_cell(addr);
        collect(stall);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int highs;

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_value("rst_in_ready",  64'(in_ready),  64'd0);
        check_value("rst_out_valid", 64'(out_valid), 64'd0);
        check_value("rst_p",         64'(p_out),     64'd0);
        check_value("rst_ovf",       64'(ovf_out),   64'd0);
        RESET = 1'b0;
        repeat (2) begin @(posedge CLOCK_50); #1; end
        check_value("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Rest cell
        fv = '{default: 32'h0};
        fv[0] = 32'h0100_0000;
        run_cell(8'h01, 0);

        // East flow
        fv = '{default: 32'h0};
        fv[0] = 32'h0080_0000; fv[1] = 32'h0080_0000;
        run_cell(8'h02, 0);

        // West/north mix
        fv = '{default: 32'h0};
        fv[0] = 32'h0080_0000; fv[3] = 32'h0040_0000; fv[2] = 32'h0040_0000;
        run_cell(8'h03, 0);

        // Zero density
        fv = '{default: 32'h0};
        run_cell(8'h37, 0);

        // Velocity overflow, with output backpressure
        fv = '{default: 32'h0};
        fv[1] = 32'h4000_0000; fv[3] = 32'hC040_0000;
        run_cell(8'h05, 5);

        // Negative density: velocities forced to zero
        fv = '{default: 32'h0};
        fv[0] = 32'hFF00_0000; fv[1] = 32'h0080_0000; fv[2] = 32'h0010_0000;
        run_cell(8'h06, 0);

        // Random positive cells
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 9; i++) fv[i] = $urandom_range(32'h00FF_FFFF, 0);
            run_cell(8'(8'h40 + r), (r == 2) ? 3 : 0);
        end

        // Reset in the middle of a divide aborts the cell
        fv = '{default: 32'h0};
        fv[0] = 32'h0080_0000; fv[1] = 32'h0080_0000;
        send_cell(8'h77);
        repeat (20) @(posedge CLOCK_50);
        #1;
        RESET = 1'b1;
        #1;
        check_value("abort_out_valid", 64'(out_valid), 64'd0);
        check_value("abort_in_ready",  64'(in_ready),  64'd0);
        check_value("abort_p",         64'(p_out),     64'd0);
        check_value("abort_ux",        64'(ux_out),    64'd0);
        check_value("abort_addr",      64'(addr_out),  64'd0);
        void'(sb_q.pop_back());
        repeat (2) @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
        repeat (2) begin @(posedge CLOCK_50); #1; end
        check_value("abort_in_ready_rel", 64'(in_ready), 64'd1);
        highs = 0;
        repeat (80) begin
            @(posedge CLOCK_50); #1;
            if (out_valid) highs++;
        end
        check_value("abort_no_result", 64'(highs), 64'd0);

        // Recovery after abort
        fv = '{default: 32'h0};
        fv[0] = 32'h0100_0000; fv[4] = 32'h0020_0000;
        run_cell(8'h08, 0);

        check_value("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
